// File: rtl/block_memory_responder.sv
// Main-memory responder for the direct-mapped cache: returns an aligned block
// after a fixed latency and accepts single-word write-through stores.
module block_memory_responder #(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_SIZE  = 32,
    parameter int WORD_COUNT = 4,
    parameter int LATENCY    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            memRead,
    input  logic                            memWrite,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic [WORD_SIZE-1:0]            writeData,
    output logic [WORD_SIZE*WORD_COUNT-1:0] blockOut,
    output logic                            blockValid,
    output logic                            busy,
    output logic [15:0]                     readCount
);

    localparam int OFF_W   = $clog2(WORD_COUNT);
    localparam int BLOCK_W = ADDR_WIDTH - OFF_W;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                          stateQ;
    logic [CNT_W-1:0]                cntQ;
    logic [BLOCK_W-1:0]              blockIdxQ;
    logic [WORD_SIZE*WORD_COUNT-1:0] blockOutQ;
    logic                            blockValidQ;
    logic                            busyQ;
    logic [15:0]                     readCountQ;

    logic [WORD_SIZE-1:0]            mem [DEPTH];

    // Backing store has no reset; stores only land while idle so an
    // in-flight refill always sees a stable block.
    always_ff @(posedge clk) begin
        if (stateQ == S_IDLE && memWrite) begin
            mem[address] <= writeData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= S_IDLE;
            cntQ        <= '0;
            blockIdxQ   <= '0;
            blockOutQ   <= '0;
            blockValidQ <= 1'b0;
            busyQ       <= 1'b0;
            readCountQ  <= '0;
        end else begin
            case (stateQ)
                S_IDLE: begin
                    if (memRead) begin
                        blockIdxQ <= address[ADDR_WIDTH-1:OFF_W];
                        cntQ      <= CNT_W'(LATENCY - 1);
                        busyQ     <= 1'b1;
                        stateQ    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cntQ != '0) begin
                        cntQ <= cntQ - CNT_W'(1);
                    end else begin
                        // Same-edge write in IDLE was already committed, so
                        // the gathered block reflects it.
                        for (int w = 0; w < WORD_COUNT; w++) begin
                            blockOutQ[w*WORD_SIZE +: WORD_SIZE] <= mem[{blockIdxQ, OFF_W'(w)}];
                        end
                        blockValidQ <= 1'b1;
                        stateQ      <= S_DONE;
                    end
                end
                S_DONE: begin
                    blockValidQ <= 1'b0;
                    busyQ       <= 1'b0;
                    if (readCountQ != 16'hFFFF) begin
                        readCountQ <= readCountQ + 16'd1;
                    end
                    stateQ <= S_IDLE;
                end
                default: begin
                    stateQ      <= S_IDLE;
                    blockValidQ <= 1'b0;
                    busyQ       <= 1'b0;
                end
            endcase
        end
    end

    assign blockOut   = blockOutQ;
    assign blockValid = blockValidQ;
    assign busy       = busyQ;
    assign readCount  = readCountQ;

endmodule
